// File: rtl/dft_source_collector_pkg.sv
// Shared types and constants for the DFT source-side collector.
// DENORM_SAT_EN (when defined) enables saturating denormalization in the top.
package dft_collect_pkg;

  localparam int DW            = 18;
  localparam int EW            = 4;
  localparam int OW            = 30;
  localparam int TS_W          = 16;
  localparam int TAG_DEPTH_DEF = 4;
  localparam int NSIZES        = 36;

  // DFT point counts indexed by size code
  localparam logic [11:0] PTS_LUT [0:NSIZES-1] = '{
    12'd12,   12'd24,   12'd36,   12'd48,   12'd60,   12'd72,
    12'd96,   12'd108,  12'd120,  12'd144,  12'd180,  12'd192,
    12'd216,  12'd240,  12'd288,  12'd300,  12'd324,  12'd360,
    12'd384,  12'd432,  12'd480,  12'd540,  12'd576,  12'd600,
    12'd648,  12'd720,  12'd768,  12'd864,  12'd900,  12'd960,
    12'd972,  12'd1080, 12'd1152, 12'd1200, 12'd1296, 12'd1536
  };

  typedef struct packed {
    logic [5:0]      size;
    logic [TS_W-1:0] ts;
  } tag_t;

  typedef enum logic [0:0] {IDLE = 1'b0, INFRAME = 1'b1} state_t;

  // Unknown size codes map to 0 points so any real frame flags a length error
  function automatic logic [11:0] pts(input logic [5:0] s);
    logic [11:0] r;
    r = 12'd0;
    if (s < 6'd36) r = PTS_LUT[s];
    return r;
  endfunction

endpackage

// File: rtl/dft_source_collector_if.sv
// Sink-tag, source-stream, denormalized-stream and frame-status bundle.
// DENORM_SAT_EN adds the sat_flag signal.
interface dft_source_collector_if;
  import dft_collect_pkg::*;

  logic            sink_sop;
  logic [5:0]      size;
  logic            source_valid;
  logic            source_sop;
  logic            source_eop;
  logic [DW-1:0]   source_real;
  logic [DW-1:0]   source_imag;
  logic [EW-1:0]   source_exp;
  logic            out_valid;
  logic            out_sop;
  logic            out_eop;
  logic [OW-1:0]   out_real;
  logic [OW-1:0]   out_imag;
  logic            frm_done;
  logic [11:0]     frm_len;
  logic            len_err;
  logic [TS_W-1:0] lat_val;
  logic            proto_err;
  logic            tag_ovf;
`ifdef DENORM_SAT_EN
  logic            sat_flag;
`endif

  modport master (
    output sink_sop, size, source_valid, source_sop, source_eop,
           source_real, source_imag, source_exp,
    input  out_valid, out_sop, out_eop, out_real, out_imag,
           frm_done, frm_len, len_err, lat_val, proto_err, tag_ovf
`ifdef DENORM_SAT_EN
    , input sat_flag
`endif
  );

  modport slave (
    input  sink_sop, size, source_valid, source_sop, source_eop,
           source_real, source_imag, source_exp,
    output out_valid, out_sop, out_eop, out_real, out_imag,
           frm_done, frm_len, len_err, lat_val, proto_err, tag_ovf
`ifdef DENORM_SAT_EN
    , output sat_flag
`endif
  );

endinterface

// File: rtl/dft_source_collector_tag_fifo.sv
// In-flight frame tag FIFO; push while full is accepted only alongside a pop.
module dft_tag_fifo
  import dft_collect_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_pop,
  input  tag_t i_din,
  output tag_t o_head,
  output logic o_full,
  output logic o_empty
);
  localparam int AW = $clog2(DEPTH);

  tag_t        r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        w_do_pop;
  logic        w_do_push;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/dft_source_collector.sv
// Denormalizes the DFT output stream and reports per-frame length/latency status.
// DENORM_SAT_EN selects saturating shift and adds the sticky sat_flag output.
module dft_source_collector
  import dft_collect_pkg::*;
#(
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  dft_source_collector_if.slave  bus
);

`ifdef DENORM_SAT_EN
  localparam int WW = DW + (1 << EW) - 1;

  // MSB of the result flags an overflowed (clamped) value
  function automatic logic [OW:0] denorm(input logic [DW-1:0] v, input logic [EW-1:0] e);
    logic [WW-1:0]    wide;
    logic [WW-OW:0]   hi;
    logic             ovf;
    logic [OW-1:0]    val;
    wide = {{(WW-DW){v[DW-1]}}, v} << e;
    hi   = wide[WW-1:OW-1];
    ovf  = !((hi == '0) || (hi == '1));
    val  = wide[OW-1:0];
    if (ovf) val = v[DW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    return {ovf, val};
  endfunction
`else
  function automatic logic [OW:0] denorm(input logic [DW-1:0] v, input logic [EW-1:0] e);
    logic [OW-1:0] val;
    val = {{(OW-DW){v[DW-1]}}, v} << e;
    return {1'b0, val};
  endfunction
`endif

  state_t          r_state;
  logic [11:0]     r_cnt;
  logic [TS_W-1:0] r_ts;
  logic            r_out_valid, r_out_sop, r_out_eop;
  logic [OW-1:0]   r_out_real, r_out_imag;
  logic            r_frm_done, r_len_err, r_proto_err, r_tag_ovf;
  logic [11:0]     r_frm_len;
  logic [TS_W-1:0] r_lat;
`ifdef DENORM_SAT_EN
  logic            r_sat;
`endif

  logic            w_acc, w_stray, w_mid_sop, w_close, w_ovf;
  logic [11:0]     w_cnt_nxt;
  logic [OW:0]     w_dn_re, w_dn_im;
  tag_t            w_head, w_push_tag;
  logic            w_full, w_empty;

  // A beat is taken when a frame is open or it opens one
  assign w_acc      = bus.source_valid & ((r_state == INFRAME) | bus.source_sop);
  assign w_stray    = bus.source_valid & (r_state == IDLE) & ~bus.source_sop;
  assign w_mid_sop  = bus.source_valid & (r_state == INFRAME) & bus.source_sop;
  assign w_close    = w_acc & bus.source_eop;
  assign w_cnt_nxt  = bus.source_sop ? 12'd1 : r_cnt + 12'd1;
  assign w_ovf      = bus.sink_sop & w_full & ~w_close;
  assign w_dn_re    = denorm(bus.source_real, bus.source_exp);
  assign w_dn_im    = denorm(bus.source_imag, bus.source_exp);
  assign w_push_tag = '{size: bus.size, ts: r_ts};

  dft_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.sink_sop),
    .i_pop   (w_close),
    .i_din   (w_push_tag),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ts        <= '0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_real  <= '0;
      r_out_imag  <= '0;
      r_frm_done  <= 1'b0;
      r_frm_len   <= '0;
      r_len_err   <= 1'b0;
      r_lat       <= '0;
      r_proto_err <= 1'b0;
      r_tag_ovf   <= 1'b0;
`ifdef DENORM_SAT_EN
      r_sat       <= 1'b0;
`endif
    end else begin
      r_ts        <= r_ts + TS_W'(1);
      r_out_valid <= w_acc;
      r_out_sop   <= w_acc & bus.source_sop;
      r_out_eop   <= w_close;
      r_frm_done  <= w_close;
      if (bus.source_valid) begin
        r_out_real <= w_dn_re[OW-1:0];
        r_out_imag <= w_dn_im[OW-1:0];
      end
      if (w_acc) begin
        r_state <= bus.source_eop ? IDLE : INFRAME;
        r_cnt   <= w_cnt_nxt;
      end
      // Lost tags (empty FIFO at close) report zero latency and no length error
      if (w_close) begin
        r_frm_len <= w_cnt_nxt;
        if (!w_empty) begin
          r_len_err <= (w_cnt_nxt != pts(w_head.size));
          r_lat     <= TS_W'(r_ts - w_head.ts + TS_W'(1));
        end else begin
          r_len_err <= 1'b0;
          r_lat     <= '0;
        end
      end
      if (w_stray | w_mid_sop | (w_close & w_empty)) r_proto_err <= 1'b1;
      if (w_ovf) r_tag_ovf <= 1'b1;
`ifdef DENORM_SAT_EN
      if (w_acc & (w_dn_re[OW] | w_dn_im[OW])) r_sat <= 1'b1;
`endif
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_sop   = r_out_sop;
  assign bus.out_eop   = r_out_eop;
  assign bus.out_real  = r_out_real;
  assign bus.out_imag  = r_out_imag;
  assign bus.frm_done  = r_frm_done;
  assign bus.frm_len   = r_frm_len;
  assign bus.len_err   = r_len_err;
  assign bus.lat_val   = r_lat;
  assign bus.proto_err = r_proto_err;
  assign bus.tag_ovf   = r_tag_ovf;
`ifdef DENORM_SAT_EN
  assign bus.sat_flag  = r_sat;
`endif

endmodule

// File: doc/dft_source_collector.md
Name: dft_source_collector

Overview:
Synthesizable receive-side companion to the mixed-radix DFT core. It consumes the core's output stream (source_valid/sop/eop/real/imag/exp) and denormalizes each sample by its block exponent into a wide signed result. It checks frame length against the size requested at the matching sink_sop, and reports per-frame sink_sop→source_eop latency. It sits after top_mixed_radix_dft_0 and feeds the capture/compare logic.

Parameters:
DW, 18, input sample width (signed)
EW, 4, block exponent width
OW, 30, denormalized output width (signed)
TAG_DEPTH, 4, in-flight frame tag FIFO depth (power of 2)
TS_W, 16, timestamp / latency counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
sink_sop  in  1  input-side frame start seen by the DFT core (tag push)
size  in  6  size code 0..35 valid with sink_sop
source_valid  in  1  DFT output beat valid
source_sop  in  1  first beat of output frame
source_eop  in  1  last beat of output frame
source_real  in  DW  signed output real
source_imag  in  DW  signed output imag
source_exp  in  EW  block exponent, unsigned
out_valid  out  1  denormalized beat valid
out_sop  out  1  first beat
out_eop  out  1  last beat
out_real  out  OW  source_real * 2^source_exp, signed
out_imag  out  OW  source_imag * 2^source_exp, signed
frm_done  out  1  one-cycle pulse, frame status valid
frm_len  out  12  beats counted in finished frame
len_err  out  1  with frm_done: frm_len != expected points
lat_val  out  TS_W  latency of finished frame (sink_sop to source_eop, inclusive)
proto_err  out  1  sticky protocol error flag
tag_ovf  out  1  sticky: sink_sop with tag FIFO full

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0, FSM IDLE, FIFO empty, timestamp 0, counters 0. Reset mid-frame discards the frame; no frm_done.
- Timestamp: free-running TS_W counter, wraps modulo 2^TS_W.
- Tag FIFO: on sink_sop push {size, timestamp}. If full: drop the push and set tag_ovf. Pop on the closing source_eop beat.
- Datapath: one register stage, so outputs lag input by 1 cycle. out_real = sign-extend(source_real) <<< source_exp. source_exp is sampled every valid beat. Bits shifted beyond OW are discarded, with no saturation. out_sop/out_eop are only asserted when the beat is accepted by the FSM.
- FSM IDLE: valid&sop → INFRAME, beat count=1. Valid without sop → beat dropped (out_valid=0), proto_err=1. Valid&sop&eop → single-beat frame: close immediately, stay IDLE.
- FSM INFRAME: each valid beat increments the count. Valid&eop → close, go to IDLE. Valid&sop → proto_err=1; the old frame is abandoned without frm_done and no pop; restart the count at 1.
- Close, registered with the last out beat:
  - frm_done=1 and frm_len=count.
  - If FIFO non-empty: expected = pts(head.size), len_err = (count != expected), lat_val = timestamp − head.ts + 1 (mod 2^TS_W), then pop.
  - If FIFO empty: len_err=0, lat_val=0, proto_err=1.
- Simultaneous sink_sop and closing source_eop on the same cycle: pop and push both occur. With a full FIFO the push succeeds; with an empty FIFO the pop sees the empty state first and the push lands.
- Invalid size code (>35): pts=0, so len_err=1 on that frame.
- proto_err and tag_ovf clear only on rst.

Optional Feature:
- DENORM_SAT_EN: when defined, out_real/out_imag saturate to ±(2^(OW−1)−1) on shift overflow (most-negative value clamps to −2^(OW−1)), and sticky sat_flag (added output, 1 bit) is set.
- When undefined: plain truncating shift, and no sat_flag port.

Decomposition:
- Package dft_collect_pkg holds:
  - constant array PTS_LUT[0:35] of 12-bit points: 12,24,36,48,60,72,96,108,120,144,180,192,216,240,288,300,324,360,384,432,480,540,576,600,648,720,768,864,900,960,972,1080,1152,1200,1296,1536
  - typedef tag_t {size[5:0], ts[TS_W-1:0]}
  - enum state_t {IDLE, INFRAME}
- One sub-module: dft_tag_fifo (synchronous FIFO of tag_t with push/pop/full/empty, simultaneous push+pop legal).

Test Plan:
1. Push size=0 at t=0; 12-beat frame (sop beat 0, eop beat 11) with exp=2 and real=−3 on all beats, eop at t=75 → out_real=−12, frm_len=12, len_err=0, lat_val=76.
2. Push size=33 (1200); output frame of 1199 beats → frm_done with frm_len=1199, len_err=1, FIFO empty afterward.
3. Five sink_sop with no output → tag_ovf=1 after the 5th. Then four well-formed frames drain the FIFO with len_err=0 and no proto_err.
4. Valid beat without sop in IDLE, then sop mid-frame → proto_err=1, the first frame produces no frm_done, and the restarted frame completes normally.
5. Timestamp wrap: push at ts=65530 with eop arriving 20 cycles later → lat_val=21.
6. With DENORM_SAT_EN: real=131071, exp=15 → out_real=536870911 and sat_flag=1. Without it → truncated value 131071<<15 mod 2^30, read as signed.
